uc_fila_posicoes: RTL and testbench

Control unit with an internal position queue, a parametrised successor to the single-register receive/open controller. Every received data word (`comando`=0) is pushed into a FIFO of stored positions. Every received command word (`comando`=1) pops the oldest position and holds `abrir` high for a programmable number of cycles. The block sits between the serial receiver (`fimRecepcao`, `dado`, `comando`) and the actuator/servo driver (`abrir`, `posicao`). It flags overflow, underflow and words that arrive while busy.

---
 rtl/uc_pkg.sv | 39 +++
 rtl/fila_posicoes.sv | 59 +++++
 rtl/uc_fila_posicoes.sv | 126 ++++++++++++
 tb/tb_uc_fila_posicoes.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// uc_pkg: shared state encodings, display codes and width helpers for the
// position-queue control unit.
package uc_pkg;

  // Controller states; values double as the low bits of the display code.
  typedef enum logic [2:0] {
    S_INICIAL  = 3'd0,
    S_ESPERA   = 3'd1,
    S_ARMAZENA = 3'd2,
    S_MUDAR    = 3'd3,
    S_ERRO     = 3'd4
  } estado_t;

  // Codes shown on dbEstado.
  localparam logic [3:0] DB_INICIAL  = 4'h0;
  localparam logic [3:0] DB_ESPERA   = 4'h1;
  localparam logic [3:0] DB_ARMAZENA = 4'h2;
  localparam logic [3:0] DB_MUDAR    = 4'h3;
  localparam logic [3:0] DB_ERRO     = 4'h4;
  localparam logic [3:0] DB_INVALIDO = 4'hF;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned valor);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(valor)) r = i + 1;
    end
    return r;
  endfunction

  // Width of a register able to index/count 'valor' items, never below 1 bit.
  function automatic int unsigned largura_min1(input int unsigned valor);
    int unsigned r;
    r = clog2(valor);
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/fila_posicoes.sv
// fila_posicoes: circular queue of stored positions.
// Ports: clock/reset (sync, active-low); limpa clears everything;
// push writes dado at wr_ptr; pop advances rd_ptr; leitura is the oldest
// entry; ocupacao/vazio/cheio report the fill level.
module fila_posicoes
  import uc_pkg::*;
#(
  parameter int unsigned LARGURA      = 8,
  parameter int unsigned PROFUNDIDADE = 4,
  localparam int unsigned OCUP_W      = clog2(PROFUNDIDADE + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                limpa,
  input  logic                push,
  input  logic                pop,
  input  logic [LARGURA-1:0]  dado,
  output logic [LARGURA-1:0]  leitura,
  output logic [OCUP_W-1:0]   ocupacao,
  output logic                vazio,
  output logic                cheio
);

  localparam int unsigned PTR_W = largura_min1(PROFUNDIDADE);

  logic [LARGURA-1:0] slot [PROFUNDIDADE];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [OCUP_W-1:0]  ocup;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] proximo(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(PROFUNDIDADE - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage, pointers and count.
  always_ff @(posedge clock) begin
    if (!reset || limpa) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ocup   <= '0;
      slot   <= '{default: '0};
    end else begin
      if (push) begin
        slot[wr_ptr] <= dado;
        wr_ptr       <= proximo(wr_ptr);
      end
      if (pop) rd_ptr <= proximo(rd_ptr);
      if (push && !pop) ocup <= ocup + 1'b1;
      else if (pop && !push) ocup <= ocup - 1'b1;
    end
  end

  assign leitura  = slot[rd_ptr];
  assign ocupacao = ocup;
  assign vazio    = (ocup == '0);
  assign cheio    = (ocup == OCUP_W'(PROFUNDIDADE));

endmodule

// File: rtl/uc_fila_posicoes.sv
// uc_fila_posicoes: receive/open control unit with a queue of positions.
// Ports: clock/reset (sync, active-low); fimRecepcao/comando/dado from the
// serial receiver; abrir/posicao to the actuator; ocupacao/vazio/cheio queue
// status; armazenado/erro one-cycle event pulses; descartado marks a word
// ignored while opening; dbEstado is the state code for the display.
module uc_fila_posicoes
  import uc_pkg::*;
#(
  parameter int unsigned LARGURA_DADO = 8,
  parameter int unsigned PROFUNDIDADE = 4,
  parameter int unsigned CICLOS_ABRIR = 1000,
  localparam int unsigned OCUP_W      = clog2(PROFUNDIDADE + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    fimRecepcao,
  input  logic                    comando,
  input  logic [LARGURA_DADO-1:0] dado,
  output logic                    abrir,
  output logic [LARGURA_DADO-1:0] posicao,
  output logic [OCUP_W-1:0]       ocupacao,
  output logic                    vazio,
  output logic                    cheio,
  output logic                    armazenado,
  output logic                    erro,
  output logic                    descartado,
  output logic [3:0]              dbEstado
);

  localparam int unsigned CNT_W = largura_min1(CICLOS_ABRIR);

  estado_t                 estado;
  logic [CNT_W-1:0]        cnt;
  logic                    cnt_fim;
  logic                    push_c;
  logic                    pop_c;
  logic                    limpa_c;
  logic [LARGURA_DADO-1:0] leitura;

  assign cnt_fim = (cnt == CNT_W'(CICLOS_ABRIR - 1));
  assign push_c  = (estado == S_ESPERA) && fimRecepcao && !comando && !cheio;
  assign pop_c   = (estado == S_MUDAR) && cnt_fim;
  assign limpa_c = (estado == S_INICIAL);

  fila_posicoes #(
    .LARGURA      (LARGURA_DADO),
    .PROFUNDIDADE (PROFUNDIDADE)
  ) u_fila (
    .clock    (clock),
    .reset    (reset),
    .limpa    (limpa_c),
    .push     (push_c),
    .pop      (pop_c),
    .dado     (dado),
    .leitura  (leitura),
    .ocupacao (ocupacao),
    .vazio    (vazio),
    .cheio    (cheio)
  );

  // State register and opening-window counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado <= S_INICIAL;
      cnt    <= '0;
    end else begin
      case (estado)
        S_INICIAL: begin
          estado <= S_ESPERA;
          cnt    <= '0;
        end
        S_ESPERA: begin
          cnt <= '0;
          if (fimRecepcao) begin
            if (!comando) estado <= cheio ? S_ERRO : S_ARMAZENA;
            else          estado <= vazio ? S_ERRO : S_MUDAR;
          end
        end
        S_ARMAZENA, S_ERRO: estado <= S_ESPERA;
        S_MUDAR: begin
          if (cnt_fim) begin
            estado <= S_ESPERA;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          estado <= S_INICIAL;
          cnt    <= '0;
        end
      endcase
    end
  end

  // Moore decode of the registered state.
  always_comb begin
    abrir      = 1'b0;
    posicao    = '0;
    armazenado = 1'b0;
    erro       = 1'b0;
    dbEstado   = DB_INVALIDO;
    case (estado)
      S_INICIAL:  dbEstado = DB_INICIAL;
      S_ESPERA:   dbEstado = DB_ESPERA;
      S_ARMAZENA: begin
        dbEstado   = DB_ARMAZENA;
        armazenado = 1'b1;
      end
      S_MUDAR: begin
        dbEstado = DB_MUDAR;
        abrir    = 1'b1;
        posicao  = leitura;
      end
      S_ERRO: begin
        dbEstado = DB_ERRO;
        erro     = 1'b1;
      end
      default: dbEstado = DB_INVALIDO;
    endcase
  end

  // Words arriving while opening are dropped; flag them immediately.
  assign descartado = (estado == S_MUDAR) && fimRecepcao;

endmodule

// File: tb/tb_uc_fila_posicoes.sv
// tb_uc_fila_posicoes: directed stimulus with a queue-level reference model
// checked every cycle, plus literal expectations on the scenarios.
module tb_uc_fila_posicoes;

  localparam int LD   = 8;
  localparam int PROF = 3;
  localparam int CIC  = 3;

  localparam int M_INI = 0;
  localparam int M_ESP = 1;
  localparam int M_ARM = 2;
  localparam int M_ABR = 3;
  localparam int M_ERR = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          fimRecepcao = 1'b0;
  logic          comando = 1'b0;
  logic [LD-1:0] dado = '0;
  logic          abrir;
  logic [LD-1:0] posicao;
  logic [1:0]    ocupacao;
  logic          vazio;
  logic          cheio;
  logic          armazenado;
  logic          erro;
  logic          descartado;
  logic [3:0]    dbEstado;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  uc_fila_posicoes #(
    .LARGURA_DADO (LD),
    .PROFUNDIDADE (PROF),
    .CICLOS_ABRIR (CIC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .fimRecepcao (fimRecepcao),
    .comando     (comando),
    .dado        (dado),
    .abrir       (abrir),
    .posicao     (posicao),
    .ocupacao    (ocupacao),
    .vazio       (vazio),
    .cheio       (cheio),
    .armazenado  (armazenado),
    .erro        (erro),
    .descartado  (descartado),
    .dbEstado    (dbEstado)
  );

  task automatic chk(input string nome, input int atual, input int esperado);
    checks++;
    if (atual != esperado) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               nome, atual, atual, esperado, esperado, $time);
    end
  endtask

  // Reference model: a plain queue plus "what the block is doing this cycle".
  // Inputs are driven just after a rising edge, so the values seen at a
  // falling edge are exactly what the next rising edge samples.
  int  q[$];
  int  modo = M_INI;
  int  restante = 0;
  bit  armed = 0;
  bit  have_prev = 0;
  bit  p_rst, p_fim, p_com;
  int  p_dado;

  always @(negedge clock) begin
    if (have_prev) begin
      if (!p_rst) begin
        q.delete();
        modo     = M_INI;
        restante = 0;
        armed    = 1;
      end else if (modo == M_ABR) begin
        restante--;
        if (restante == 0) begin
          void'(q.pop_front());
          modo = M_ESP;
        end
      end else if (modo != M_ESP) begin
        modo = M_ESP;
      end else if (p_fim) begin
        if (!p_com) begin
          if (q.size() < PROF) begin
            q.push_back(p_dado);
            modo = M_ARM;
          end else begin
            modo = M_ERR;
          end
        end else if (q.size() > 0) begin
          modo     = M_ABR;
          restante = CIC;
        end else begin
          modo = M_ERR;
        end
      end
    end
    if (armed) begin
      chk("abrir", int'(abrir), int'(modo == M_ABR));
      chk("posicao", int'(posicao), (modo == M_ABR) ? q[0] : 0);
      chk("ocupacao", int'(ocupacao), q.size());
      chk("vazio", int'(vazio), int'(q.size() == 0));
      chk("cheio", int'(cheio), int'(q.size() == PROF));
      chk("armazenado", int'(armazenado), int'(modo == M_ARM));
      chk("erro", int'(erro), int'(modo == M_ERR));
      chk("dbEstado", int'(dbEstado), modo);
      chk("descartado", int'(descartado), int'(modo == M_ABR && fimRecepcao));
    end
    p_rst     = reset;
    p_fim     = fimRecepcao;
    p_com     = comando;
    p_dado    = int'(dado);
    have_prev = 1;
  end

  task automatic wait1();
    @(posedge clock);
    #1;
  endtask

  // One-cycle receive pulse; returns at the start of the following cycle.
  task automatic send(input bit c, input logic [LD-1:0] d);
    fimRecepcao = 1'b1;
    comando     = c;
    dado        = d;
    wait1();
    fimRecepcao = 1'b0;
    comando     = 1'b0;
  endtask

  // Command, then count abrir cycles and pin posicao inside the window.
  task automatic pop_check(input int esperado, input string nome);
    int n;
    n = 0;
    send(1'b1, '0);
    repeat (6) begin
      @(negedge clock);
      if (abrir) begin
        n++;
        chk({nome, "_posicao"}, int'(posicao), esperado);
      end
      wait1();
    end
    chk({nome, "_janela"}, n, CIC);
  endtask

  initial begin
    // 1. reset
    repeat (2) wait1();
    reset = 1'b1;
    @(negedge clock);
    chk("t1_db_inicial", int'(dbEstado), 0);
    chk("t1_vazio_inicial", int'(vazio), 1);
    wait1();
    @(negedge clock);
    chk("t1_db_espera", int'(dbEstado), 1);
    chk("t1_ocupacao", int'(ocupacao), 0);
    chk("t1_abrir", int'(abrir), 0);
    wait1();

    // 2. fill, then overflow
    send(1'b0, 8'h11);
    @(negedge clock);
    chk("t2_arm1", int'(armazenado), 1);
    chk("t2_ocup1", int'(ocupacao), 1);
    wait1();
    send(1'b0, 8'h22);
    @(negedge clock);
    chk("t2_arm2", int'(armazenado), 1);
    chk("t2_ocup2", int'(ocupacao), 2);
    wait1();
    send(1'b0, 8'h33);
    @(negedge clock);
    chk("t2_arm3", int'(armazenado), 1);
    chk("t2_ocup3", int'(ocupacao), 3);
    chk("t2_cheio", int'(cheio), 1);
    wait1();
    send(1'b0, 8'h44);
    @(negedge clock);
    chk("t2_erro", int'(erro), 1);
    chk("t2_db_erro", int'(dbEstado), 4);
    chk("t2_ocup_mantida", int'(ocupacao), 3);
    wait1();

    // 3. drain in order, then underflow
    pop_check(8'h11, "t3_pop1");
    pop_check(8'h22, "t3_pop2");
    pop_check(8'h33, "t3_pop3");
    @(negedge clock);
    chk("t3_vazio", int'(vazio), 1);
    wait1();
    send(1'b1, '0);
    @(negedge clock);
    chk("t3_erro", int'(erro), 1);
    chk("t3_abrir", int'(abrir), 0);
    wait1();

    // 4. write pointer wrap-around
    send(1'b0, 8'hA0);
    wait1();
    send(1'b0, 8'hA1);
    wait1();
    pop_check(8'hA0, "t4_pop0");
    send(1'b0, 8'hA2);
    wait1();
    send(1'b0, 8'hA3);
    wait1();
    pop_check(8'hA1, "t4_pop1");
    pop_check(8'hA2, "t4_pop2");
    pop_check(8'hA3, "t4_pop3");

    // 5. word dropped during opening
    send(1'b0, 8'h55);
    wait1();
    send(1'b1, '0);
    wait1();
    fimRecepcao = 1'b1;
    comando     = 1'b0;
    dado        = 8'h66;
    @(negedge clock);
    chk("t5_descartado", int'(descartado), 1);
    chk("t5_abrir", int'(abrir), 1);
    chk("t5_posicao", int'(posicao), 8'h55);
    wait1();
    fimRecepcao = 1'b0;
    wait1();
    @(negedge clock);
    chk("t5_ocupacao", int'(ocupacao), 0);
    chk("t5_vazio", int'(vazio), 1);
    wait1();

    // 6. reset in the middle of an opening
    send(1'b0, 8'h77);
    wait1();
    send(1'b1, '0);
    wait1();
    reset = 1'b0;
    wait1();
    reset = 1'b1;
    @(negedge clock);
    chk("t6_abrir", int'(abrir), 0);
    chk("t6_db", int'(dbEstado), 0);
    chk("t6_ocupacao", int'(ocupacao), 0);
    wait1();
    send(1'b1, '0);
    @(negedge clock);
    chk("t6_erro", int'(erro), 1);
    wait1();

    // 7. reset wins over a simultaneous push
    reset       = 1'b0;
    fimRecepcao = 1'b1;
    comando     = 1'b0;
    dado        = 8'h99;
    wait1();
    fimRecepcao = 1'b0;
    reset       = 1'b1;
    @(negedge clock);
    chk("t7_ocupacao", int'(ocupacao), 0);
    chk("t7_db", int'(dbEstado), 0);
    repeat (3) wait1();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
